// File: rtl/fnv_map_pkg.sv
// Shared types and helpers for the fnvMap sequencer: widths, FNV prime,
// sequencer states, the command bundle and the FNV combine function.
package fnv_map_pkg;

   localparam int ADDR_W = 8;
   localparam int LEN_W  = 9;
   localparam logic [31:0] FNV_PRIME = 32'h0100_0193;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } seq_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] origin;
      logic [ADDR_W-1:0] modifier;
      logic [LEN_W-1:0]  length;
      logic              cond_pass;
   } fnv_cmd_t;

   function automatic logic [31:0] fnv32(input logic [31:0] x, input logic [31:0] y);
      return (x * FNV_PRIME) ^ y;
   endfunction

endpackage

// File: rtl/fnv_map_datapath.sv
// Write-back stage: delays the read address by one cycle and combines the
// returned A/B words into the FNV write value.
module fnv_map_datapath
   import fnv_map_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic [31:0]       rd_data_a_i,
   input  logic [31:0]       rd_data_b_i,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [31:0]       wr_data_o
);

   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
      end else begin
         wr_en_q   <= rd_en_i;
         wr_addr_q <= rd_addr_i;
      end
   end

   // Read data arrives in the write cycle; gated so idle cycles drive zero.
   assign wr_en_o   = wr_en_q;
   assign wr_addr_o = wr_addr_q;
   assign wr_data_o = wr_en_q ? fnv32(rd_data_a_i, rd_data_b_i) : 32'h0;

endmodule

// File: rtl/fnv_map_sequencer.sv
// fnvMap sequencer: accepts one command, streams element reads one per cycle
// in a hazard-free direction and hands data to the write-back datapath.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// RUN   | one read per cycle, cnt_q = reads remaining after the current one
// DRAIN | final write completes, no read
// DONE  | one-cycle done pulse
module fnv_map_sequencer
   import fnv_map_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_origin,
   input  logic [ADDR_W-1:0] cmd_modifier,
   input  logic [LEN_W-1:0]  cmd_length,
   input  logic              cmd_cond_pass,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr_a,
   output logic [ADDR_W-1:0] rd_addr_b,
   input  logic [31:0]       rd_data_a,
   input  logic [31:0]       rd_data_b,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              busy,
   output logic              done
);

   seq_state_e        state_q;
   logic [LEN_W-1:0]  cnt_q;
   logic              desc_q;
   logic              cmd_ready_q;
   logic              busy_q;
   logic              done_q;
   logic              rd_en_q;
   logic [ADDR_W-1:0] rd_addr_a_q;
   logic [ADDR_W-1:0] rd_addr_b_q;

   fnv_cmd_t          cmd;
   logic              accept;
   logic              cmd_desc;
   logic              cmd_skip;
   logic [ADDR_W-1:0] first_k;

   assign cmd = '{origin: cmd_origin, modifier: cmd_modifier,
                  length: cmd_length, cond_pass: cmd_cond_pass};

   assign accept   = cmd_valid && cmd_ready_q;
   assign cmd_skip = !cmd.cond_pass || (cmd.length == '0);
   // Walking away from the source side means no read ever sees a fresh write.
   assign cmd_desc = cmd.modifier < cmd.origin;
   assign first_k  = cmd_desc ? ADDR_W'(cmd.length - LEN_W'(1)) : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         desc_q      <= 1'b0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_addr_a_q <= '0;
         rd_addr_b_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (cmd_skip) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q     <= RUN;
                     rd_en_q     <= 1'b1;
                     desc_q      <= cmd_desc;
                     cnt_q       <= cmd.length - LEN_W'(1);
                     rd_addr_a_q <= cmd.origin + first_k;
                     rd_addr_b_q <= cmd.modifier + first_k;
                  end
               end
            end
            RUN: begin
               if (cnt_q == '0) begin
                  rd_en_q <= 1'b0;
                  state_q <= DRAIN;
               end else begin
                  cnt_q <= cnt_q - LEN_W'(1);
                  if (desc_q) begin
                     rd_addr_a_q <= rd_addr_a_q - ADDR_W'(1);
                     rd_addr_b_q <= rd_addr_b_q - ADDR_W'(1);
                  end else begin
                     rd_addr_a_q <= rd_addr_a_q + ADDR_W'(1);
                     rd_addr_b_q <= rd_addr_b_q + ADDR_W'(1);
                  end
               end
            end
            DRAIN: begin
               state_q <= DONE;
               done_q  <= 1'b1;
            end
            DONE: begin
               state_q     <= IDLE;
               done_q      <= 1'b0;
               busy_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   fnv_map_datapath u_datapath (
      .clk         (clk),
      .reset       (reset),
      .rd_en_i     (rd_en_q),
      .rd_addr_i   (rd_addr_a_q),
      .rd_data_a_i (rd_data_a),
      .rd_data_b_i (rd_data_b),
      .wr_en_o     (wr_en),
      .wr_addr_o   (wr_addr),
      .wr_data_o   (wr_data)
   );

   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign rd_en     = rd_en_q;
   assign rd_addr_a = rd_addr_a_q;
   assign rd_addr_b = rd_addr_b_q;

endmodule
